// File: rtl/cpu7_addr_xlat_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu7_addr_xlat_pkg : shared constants, CSR field layout and types for the   |
// |                      cpu7 address translator.                               |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package cpu7_addr_xlat_pkg;

  localparam logic [13:0] CSR_CRMD = 14'h000;
  localparam logic [13:0] CSR_DMW0 = 14'h180;

  localparam int CRMD_PLV_LSB  = 0;
  localparam int CRMD_DA       = 3;
  localparam int CRMD_PG       = 4;
  localparam int CRMD_DATF_LSB = 5;
  localparam int CRMD_DATM_LSB = 7;

  localparam int DMW_PLV0     = 0;
  localparam int DMW_PLV3     = 3;
  localparam int DMW_MAT_LSB  = 4;
  localparam int DMW_PSEG_LSB = 25;
  localparam int DMW_VSEG_LSB = 29;

  localparam logic [5:0] EXC_TLBR = 6'h3F;

  typedef struct packed {
    logic [1:0] datm;
    logic [1:0] datf;
    logic       pg;
    logic       da;
    logic [1:0] plv;
  } crmd_t;

  typedef struct packed {
    logic [2:0] vseg;
    logic [2:0] pseg;
    logic [1:0] mat;
    logic       plv3;
    logic       plv0;
  } dmw_t;

  // Direct-address mode with coherent-cached fetch and data attributes.
  localparam crmd_t CRMD_RST = '{datm: 2'b01, datf: 2'b01, pg: 1'b0, da: 1'b1, plv: 2'b00};

endpackage
`default_nettype wire

// File: rtl/cpu7_addr_xlat_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu7_xlat_chan : one translation channel; accept, LAT-deep result delay,    |
// |                  hold until recv, cancel.                                   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module cpu7_xlat_chan
  import cpu7_addr_xlat_pkg::*;
#(
  parameter int LAT = 1,
  parameter int RW  = 40
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_i,
  input  logic          cancel_i,
  input  logic          recv_i,
  input  logic [RW-1:0] res_i,
  output logic          busy_o,
  output logic          finish_o,
  output logic [RW-1:0] res_o
);

  localparam int            CW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] C_LAT_M1 = CW'(LAT - 1);

  logic          pend_q, pend_d;
  logic          fin_q, fin_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] res_q, res_d;
  logic          w_accept;

  // Only one request lives in a channel; a new one enters when idle or as the held one is consumed.
  assign w_accept = req_i && !cancel_i && (!(pend_q || fin_q) || (fin_q && recv_i));

  always_comb begin
    pend_d = pend_q;
    fin_d  = fin_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    if (cancel_i) begin
      pend_d = 1'b0;
      fin_d  = 1'b0;
    end else if (w_accept) begin
      res_d  = res_i;
      pend_d = (LAT > 1);
      fin_d  = (LAT == 1);
      cnt_d  = C_LAT_M1;
    end else begin
      if (fin_q && recv_i) fin_d = 1'b0;
      if (pend_q) begin
        if (cnt_q == CW'(1)) begin
          pend_d = 1'b0;
          fin_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
      fin_q  <= 1'b0;
      cnt_q  <= '0;
      res_q  <= '0;
    end else begin
      pend_q <= pend_d;
      fin_q  <= fin_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
    end
  end

  assign busy_o   = pend_q | fin_q;
  assign finish_o = fin_q;
  assign res_o    = res_q;

endmodule
`default_nettype wire

// File: rtl/cpu7_addr_xlat.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu7_addr_xlat : NCH-channel DA/DMW address translator with CRMD/DMW CSRs.  |
// | Optional macro CPU7_XLAT_PLV_CHECK_EN gates DMW matches on privilege.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module cpu7_addr_xlat
  import cpu7_addr_xlat_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int VA_W = 32,
  parameter int PA_W = 32,
  parameter int LAT  = 1,
  parameter int NDMW = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        req,
  input  logic [NCH*VA_W-1:0]   vaddr,
  input  logic [NCH-1:0]        cancel,
  input  logic [NCH-1:0]        recv,
  output logic [NCH-1:0]        busy,
  output logic [NCH-1:0]        finish,
  output logic [NCH-1:0]        hit,
  output logic [NCH*PA_W-1:0]   paddr,
  output logic [NCH-1:0]        uncache,
  output logic [NCH*6-1:0]      exccode,
  input  logic                  csr_wen,
  input  logic [13:0]           csr_waddr,
  input  logic [31:0]           csr_wdata
);

  localparam int RW = PA_W + 8;

  crmd_t            crmd_q, crmd_d;
  dmw_t [NDMW-1:0]  dmw_q, dmw_d;
  logic [NDMW-1:0]  w_plv_ok;

  function automatic logic win_match(input logic [2:0] vseg, input logic [2:0] vtop,
                                     input logic plv_ok);
    return plv_ok && (vseg == vtop);
  endfunction

  always_comb begin
    crmd_d = crmd_q;
    dmw_d  = dmw_q;
    if (csr_wen) begin
      if (csr_waddr == CSR_CRMD) begin
        crmd_d = '{datm: csr_wdata[CRMD_DATM_LSB +: 2], datf: csr_wdata[CRMD_DATF_LSB +: 2],
                   pg:   csr_wdata[CRMD_PG],            da:   csr_wdata[CRMD_DA],
                   plv:  csr_wdata[CRMD_PLV_LSB +: 2]};
      end
      for (int k = 0; k < NDMW; k++) begin
        if (csr_waddr == CSR_DMW0 + 14'(k)) begin
          dmw_d[k] = '{vseg: csr_wdata[DMW_VSEG_LSB +: 3], pseg: csr_wdata[DMW_PSEG_LSB +: 3],
                       mat:  csr_wdata[DMW_MAT_LSB +: 2],  plv3: csr_wdata[DMW_PLV3],
                       plv0: csr_wdata[DMW_PLV0]};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_q <= CRMD_RST;
      dmw_q  <= '0;
    end else begin
      crmd_q <= crmd_d;
      dmw_q  <= dmw_d;
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^{csr_wdata[24:9], csr_wdata[2]};

`ifdef CPU7_XLAT_PLV_CHECK_EN
  // PLV 1 and 2 have no enable bit in a window, so they never match.
  always_comb begin
    w_plv_ok = '0;
    for (int k = 0; k < NDMW; k++) begin
      w_plv_ok[k] = (crmd_q.plv == 2'd0 && dmw_q[k].plv0) ||
                    (crmd_q.plv == 2'd3 && dmw_q[k].plv3);
    end
  end
`else
  assign w_plv_ok = '1;
  logic unused_plv;
  assign unused_plv = ^{crmd_q.plv, crmd_q.pg, dmw_q};
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [VA_W-1:0] w_va;
    logic            w_hit;
    logic            w_unc;
    logic [5:0]      w_exc;
    logic [PA_W-1:0] w_pa;
    logic [RW-1:0]   w_out;

    assign w_va = vaddr[i*VA_W +: VA_W];

    // Translation is evaluated against the registered CSRs, so a same-cycle write is not seen.
    always_comb begin
      w_hit = 1'b0;
      w_unc = 1'b0;
      w_exc = EXC_TLBR;
      w_pa  = w_va[PA_W-1:0];
      if (crmd_q.da) begin
        w_hit = 1'b1;
        w_exc = 6'h00;
        w_unc = (i == 0) ? (crmd_q.datf == 2'b00) : (crmd_q.datm == 2'b00);
      end else begin
        for (int k = NDMW - 1; k >= 0; k--) begin
          if (win_match(dmw_q[k].vseg, w_va[VA_W-1 -: 3], w_plv_ok[k])) begin
            w_hit = 1'b1;
            w_exc = 6'h00;
            w_unc = (dmw_q[k].mat == 2'b00);
            w_pa  = {dmw_q[k].pseg, w_va[PA_W-4:0]};
          end
        end
      end
    end

    cpu7_xlat_chan #(
      .LAT (LAT),
      .RW  (RW)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .req_i    (req[i]),
      .cancel_i (cancel[i]),
      .recv_i   (recv[i]),
      .res_i    ({w_hit, w_unc, w_exc, w_pa}),
      .busy_o   (busy[i]),
      .finish_o (finish[i]),
      .res_o    (w_out)
    );

    assign {hit[i], uncache[i], exccode[i*6 +: 6], paddr[i*PA_W +: PA_W]} = w_out;
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu7_addr_xlat.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cpu7_addr_xlat : directed and random stimulus, scoreboard per channel.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_cpu7_addr_xlat;

  localparam int NCH  = 2;
  localparam int VA_W = 32;
  localparam int PA_W = 32;
  localparam int LAT  = 1;
  localparam int NDMW = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NCH-1:0]      req, cancel, recv;
  logic [NCH*VA_W-1:0] vaddr;
  logic                csr_wen;
  logic [13:0]         csr_waddr;
  logic [31:0]         csr_wdata;
  logic [NCH-1:0]      busy, finish, hit, uncache;
  logic [NCH*PA_W-1:0] paddr;
  logic [NCH*6-1:0]    exccode;

  always #5 clk = ~clk;

  cpu7_addr_xlat #(
    .NCH(NCH), .VA_W(VA_W), .PA_W(PA_W), .LAT(LAT), .NDMW(NDMW)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .vaddr(vaddr), .cancel(cancel), .recv(recv),
    .busy(busy), .finish(finish), .hit(hit), .paddr(paddr), .uncache(uncache),
    .exccode(exccode), .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata)
  );

  typedef struct {
    logic        hit;
    logic        unc;
    logic [5:0]  exc;
    logic [31:0] pa;
    int          rise;
  } exp_t;

  exp_t        sq[NCH][$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [31:0] m_crmd;
  logic [31:0] m_dmw[NDMW];
  bit          m_busy[NCH];
  int          m_rise[NCH];

  task automatic chk(string name, int ch, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ch%0d actual=%0h required=%0h cycle=%0d", name, ch, act, exp, cyc);
    end
  endtask

  function automatic bit plv_ok(int k);
`ifdef CPU7_XLAT_PLV_CHECK_EN
    int plv;
    plv = int'(m_crmd & 32'd3);
    return (plv == 0 && m_dmw[k][0]) || (plv == 3 && m_dmw[k][3]);
`else
    return (k >= 0);
`endif
  endfunction

  function automatic exp_t ref_xlat(int ch, logic [31:0] va);
    exp_t e;
    bit   found;
    int   attr;
    e.hit = 1'b0; e.unc = 1'b0; e.exc = 6'h3F; e.pa = va; e.rise = 0;
    if (((m_crmd >> 3) & 32'd1) == 32'd1) begin
      attr  = (ch == 0) ? int'((m_crmd >> 5) & 32'd3) : int'((m_crmd >> 7) & 32'd3);
      e.hit = 1'b1; e.exc = 6'h00; e.unc = (attr == 0);
    end else begin
      found = 1'b0;
      for (int k = 0; k < NDMW; k++) begin
        if (!found && (va >> 29) == (m_dmw[k] >> 29) && plv_ok(k)) begin
          found = 1'b1;
          e.hit = 1'b1; e.exc = 6'h00;
          e.unc = (((m_dmw[k] >> 4) & 32'd3) == 32'd0);
          e.pa  = (((m_dmw[k] >> 25) & 32'd7) << 29) | (va & 32'h1FFF_FFFF);
        end
      end
    end
    return e;
  endfunction

  // Advance the model over the clock edge that just consumed the current inputs.
  task automatic model_step();
    bit   fin;
    exp_t e;
    for (int i = 0; i < NCH; i++) begin
      fin = m_busy[i] && (cyc >= m_rise[i]);
      if (cancel[i]) begin
        if (m_busy[i]) void'(sq[i].pop_back());
        m_busy[i] = 1'b0;
      end else if (req[i] && (!m_busy[i] || (fin && recv[i]))) begin
        e = ref_xlat(i, vaddr[i*VA_W +: VA_W]);
        e.rise = cyc + LAT;
        sq[i].push_back(e);
        m_busy[i] = 1'b1;
        m_rise[i] = cyc + LAT;
      end else if (fin && recv[i]) begin
        m_busy[i] = 1'b0;
      end
    end
    if (csr_wen) begin
      if (csr_waddr == 14'h000) m_crmd = csr_wdata & 32'h0000_01FB;
      else if (csr_waddr >= 14'h180 && csr_waddr < 14'h180 + 14'(NDMW))
        m_dmw[int'(csr_waddr - 14'h180)] = csr_wdata & 32'hEE00_0039;
    end
    cyc++;
  endtask

  task automatic drive(logic [NCH-1:0] rq, logic [31:0] va0, logic [31:0] va1,
                       logic [NCH-1:0] cn, logic [NCH-1:0] rv,
                       logic wen, logic [13:0] wa, logic [31:0] wd);
    @(posedge clk);
    #1;
    model_step();
    req = rq; vaddr = {va1, va0}; cancel = cn; recv = rv;
    csr_wen = wen; csr_waddr = wa; csr_wdata = wd;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < NCH; i++) begin
        bit ef;
        ef = (sq[i].size() > 0) && (sq[i][0].rise <= cyc);
        chk("busy", i, 64'(busy[i]), 64'(sq[i].size() > 0));
        chk("finish", i, 64'(finish[i]), 64'(ef));
        if (finish[i] && ef) begin
          chk("hit", i, 64'(hit[i]), 64'(sq[i][0].hit));
          chk("uncache", i, 64'(uncache[i]), 64'(sq[i][0].unc));
          chk("exccode", i, 64'(exccode[i*6 +: 6]), 64'(sq[i][0].exc));
          chk("paddr", i, 64'(paddr[i*PA_W +: PA_W]), 64'(sq[i][0].pa));
          if (recv[i] && !cancel[i]) void'(sq[i].pop_front());
        end
      end
    end
  end

  logic [NCH-1:0] r_rq, r_cn, r_rv;
  logic [31:0]    r_va0, r_va1, r_wd;
  logic [13:0]    r_wa;
  logic           r_wen;

  function automatic logic [31:0] rand_va();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 2) != 0) v[31:29] = m_dmw[$urandom_range(0, NDMW - 1)][31:29];
    return v;
  endfunction

  initial begin
    reset = 1'b1; req = '0; cancel = '0; recv = '0; vaddr = '0;
    csr_wen = 1'b0; csr_waddr = '0; csr_wdata = '0;
    m_crmd = 32'h0000_00A8;
    for (int k = 0; k < NDMW; k++) m_dmw[k] = '0;
    for (int i = 0; i < NCH; i++) begin m_busy[i] = 1'b0; m_rise[i] = 0; end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_finish", 0, 64'(finish), 64'(0));
    chk("rst_busy", 0, 64'(busy), 64'(0));
    chk("rst_hit", 0, 64'(hit), 64'(0));
    chk("rst_uncache", 0, 64'(uncache), 64'(0));
    chk("rst_paddr", 0, 64'(paddr), 64'(0));
    chk("rst_exccode", 0, 64'(exccode), 64'(0));
    mon_en = 1'b1;

    // DA mode fetch, long hold, ignored retry, back-to-back on recv
    drive(2'b01, 32'h1C00_0000, 0, 0, 0, 0, 0, 0);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("da_finish", 0, 64'(finish[0]), 64'(1));
    chk("da_hit", 0, 64'(hit[0]), 64'(1));
    chk("da_paddr", 0, 64'(paddr[31:0]), 64'h1C00_0000);
    chk("da_uncache", 0, 64'(uncache[0]), 64'(0));
    chk("da_exccode", 0, 64'(exccode[5:0]), 64'(0));
    for (int n = 0; n < 4; n++) begin
      drive(2'b01, 32'h1C00_0444, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("hold_paddr", 0, 64'(paddr[31:0]), 64'h1C00_0000);
    end
    drive(2'b01, 32'h1C00_0444, 0, 0, 2'b01, 0, 0, 0);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("b2b_finish", 0, 64'(finish[0]), 64'(1));
    chk("b2b_paddr", 0, 64'(paddr[31:0]), 64'h1C00_0444);
    drive(2'b00, 0, 0, 0, 2'b01, 0, 0, 0);

    // PG mode through DMW0
    drive(2'b00, 0, 0, 0, 0, 1'b1, 14'h000, 32'h0000_0010);
    drive(2'b00, 0, 0, 0, 0, 1'b1, 14'h180, 32'h8000_0011);
    drive(2'b10, 0, 32'h8000_1234, 0, 0, 0, 0, 0);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("dmw_hit", 1, 64'(hit[1]), 64'(1));
    chk("dmw_paddr", 1, 64'(paddr[63:32]), 64'h0000_1234);
    chk("dmw_uncache", 1, 64'(uncache[1]), 64'(0));
    drive(2'b00, 0, 0, 0, 2'b10, 0, 0, 0);

    drive(2'b10, 0, 32'h4000_0000, 0, 0, 0, 0, 0);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("miss_hit", 1, 64'(hit[1]), 64'(0));
    chk("miss_exccode", 1, 64'(exccode[11:6]), 64'h3F);
    chk("miss_paddr", 1, 64'(paddr[63:32]), 64'h4000_0000);
    drive(2'b00, 0, 0, 0, 2'b10, 0, 0, 0);

    // DMW0 rewritten in the accept cycle: old window still applies
    drive(2'b10, 0, 32'h8000_0010, 0, 0, 1'b1, 14'h180, 32'hA000_0031);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("csrsame_hit", 1, 64'(hit[1]), 64'(1));
    chk("csrsame_paddr", 1, 64'(paddr[63:32]), 64'h0000_0010);
    drive(2'b00, 0, 0, 0, 2'b10, 0, 0, 0);

    // Cancel a held result, then cancel racing a new request
    drive(2'b01, 32'h1C00_0000, 0, 0, 0, 0, 0, 0);
    drive(2'b00, 0, 0, 2'b01, 0, 0, 0, 0);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("cancel_busy", 0, 64'(busy[0]), 64'(0));
    chk("cancel_finish", 0, 64'(finish[0]), 64'(0));
    drive(2'b01, 32'h1C00_0000, 0, 2'b01, 0, 0, 0, 0);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("cancel_req_busy", 0, 64'(busy[0]), 64'(0));

    for (int n = 0; n < 3000; n++) begin
      r_rq  = NCH'($urandom);
      r_cn  = '0;
      for (int i = 0; i < NCH; i++) r_cn[i] = ($urandom_range(0, 15) == 0);
      r_rv  = ((n % 64) < 8) ? '0 : NCH'($urandom);
      r_va0 = rand_va();
      r_va1 = rand_va();
      r_wen = ($urandom_range(0, 9) == 0);
      r_wd  = $urandom;
      case ($urandom_range(0, 5))
        0: begin
          r_wa = 14'h000;
          r_wd[4:3] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        end
        1, 2, 3, 4: r_wa = 14'h180 + 14'($urandom_range(0, 3));
        default: r_wa = 14'($urandom);
      endcase
      drive(r_rq, r_va0, r_va1, r_cn, r_rv, r_wen, r_wa, r_wd);
    end
    for (int n = 0; n < 4; n++) drive('0, 0, 0, '0, '1, 0, 0, 0);
    @(negedge clk);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
